// File: rtl/dmem_arb_pkg.sv
// Shared types, constants and helpers for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned STARVE_CNT_W = 4;

    // Memory strobe encoding: low means write at the next edge.
    localparam logic MEM_WR = 1'b0;
    localparam logic MEM_RD = 1'b1;

    typedef enum logic {
        REQ_C = 1'b0,
        REQ_D = 1'b1
    } req_e;

    typedef enum logic {
        PRI_C = 1'b0,
        PRI_D = 1'b1
    } pri_e;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    // Word aligned and inside the populated word range.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                        input int unsigned       mem_words);
        return (addr[1:0] == 2'b00) &&
               ({2'b00, addr[ADDR_W-1:2]} < ADDR_W'(mem_words));
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating wait counter; hit flags the cycle the count reaches the limit.
import dmem_arb_pkg::*;

module dmem_arb_starve_ctr #(
    parameter int unsigned CNT_W = STARVE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < limit_i)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Asserted on the update that lands the count on the limit.
    assign hit_o = !clr_i && (cnt_d == limit_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core (C) and DMA/debug (D) access to the single-port data memory.
// Define DMEM_ARB_RR_EN for strict round-robin instead of C priority with D starvation override.
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_mwr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    pri_e              pri_q;
    pri_e              pri_d;
    req_e              win_id;
    logic              any_gnt;
    logic              sel_we;
    logic              sel_legal;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    rsp_t              c_rsp_q;
    rsp_t              c_rsp_d;
    rsp_t              d_rsp_q;
    rsp_t              d_rsp_d;

    // Grants are gated by rst_n so nothing reaches memory while in reset.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (c_req && d_req) begin
                if (pri_q == PRI_D) begin
                    d_gnt = 1'b1;
                end else begin
                    c_gnt = 1'b1;
                end
            end else begin
                c_gnt = c_req;
                d_gnt = d_req;
            end
        end
    end

    always_comb begin
        any_gnt   = c_gnt || d_gnt;
        win_id    = d_gnt ? REQ_D : REQ_C;
        sel_we    = (win_id == REQ_D) ? d_we    : c_we;
        sel_addr  = (win_id == REQ_D) ? d_addr  : c_addr;
        sel_wdata = (win_id == REQ_D) ? d_wdata : c_wdata;
        sel_legal = addr_legal(sel_addr, MEM_WORDS);
    end

    // Illegal accesses keep the strobe at read so memory is never disturbed.
    always_comb begin
        mem_mwr  = MEM_RD;
        mem_addr = '0;
        mem_wd   = '0;
        if (any_gnt) begin
            mem_addr = sel_addr;
            mem_wd   = sel_wdata;
            if (sel_legal && sel_we) begin
                mem_mwr = MEM_WR;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    // The state names the requester that wins the next conflict.
    always_comb begin
        pri_d = pri_q;
        if (c_gnt) begin
            pri_d = PRI_D;
        end else if (d_gnt) begin
            pri_d = PRI_C;
        end
    end
`else
    logic starve_hit;

    dmem_arb_starve_ctr #(
        .CNT_W (STARVE_CNT_W)
    ) u_starve_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (d_req && !d_gnt),
        .clr_i   (d_gnt || !d_req),
        .limit_i (STARVE_CNT_W'(STARVE_MAX)),
        .hit_o   (starve_hit)
    );

    always_comb begin
        pri_d = pri_q;
        case (pri_q)
            PRI_C:   if (starve_hit) pri_d = PRI_D;
            PRI_D:   if (d_gnt)      pri_d = PRI_C;
            default: pri_d = PRI_C;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q <= PRI_C;
        end else begin
            pri_q <= pri_d;
        end
    end

    // One-cycle response pulses; data holds its last value between pulses.
    always_comb begin
        c_rsp_d       = c_rsp_q;
        d_rsp_d       = d_rsp_q;
        c_rsp_d.valid = 1'b0;
        c_rsp_d.err   = 1'b0;
        d_rsp_d.valid = 1'b0;
        d_rsp_d.err   = 1'b0;
        if (c_gnt) begin
            if (!sel_legal) begin
                c_rsp_d = '{valid: 1'b1, err: 1'b1, data: '0};
            end else if (!sel_we) begin
                c_rsp_d = '{valid: 1'b1, err: 1'b0, data: mem_rd};
            end
        end
        if (d_gnt) begin
            if (!sel_legal) begin
                d_rsp_d = '{valid: 1'b1, err: 1'b1, data: '0};
            end else if (!sel_we) begin
                d_rsp_d = '{valid: 1'b1, err: 1'b0, data: mem_rd};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rsp_q <= '0;
            d_rsp_q <= '0;
        end else begin
            c_rsp_q <= c_rsp_d;
            d_rsp_q <= d_rsp_d;
        end
    end

    assign c_rvalid = c_rsp_q.valid;
    assign c_err    = c_rsp_q.err;
    assign c_rdata  = c_rsp_q.data;
    assign d_rvalid = d_rsp_q.valid;
    assign d_err    = d_rsp_q.err;
    assign d_rdata  = d_rsp_q.data;

endmodule
